seq_s_mpadd16: RTL and testbench
================================

# seq_s_mpadd16

Multi-precision signed adder/subtractor sequencer. It time-shares a single 16-bit ripple-carry adder slice to compute a signed (16·WORDS)-bit add or subtract, one limb per clock. The result is exact at 16·WORDS+1 bits. It sits between a requester holding wide signed operands and the narrow generated adder datapath: it replaces a wide flat adder where area matters more than latency.

## Interface
Parameters:
- WORDS, 4: number of 16-bit limbs; operand width W = 16·WORDS; legal range 2..16.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_sub  in  1  0: a+b; 1: a−b.
- in_a  in  W  signed operand a, two's complement.
- in_b  in  W  signed operand b, two's complement.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  W+1  signed result, two's complement, exact (never overflows).

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - RUN: limb counter idx steps 0..WORDS−1.
  - DONE: out_valid=1.
- Accept: in_valid && in_ready at a rising edge.
  - Register a, b and sub.
  - Set carry = sub, idx = 0, and clear the result register.
  - Go to RUN.
- RUN, each cycle:
  - Limb inputs: a_l = a[16·idx +: 16]; b_l = b[16·idx +: 16] ^ {16{sub}}.
  - Slice computes {c_out, s} = a_l + b_l + carry.
  - Write s into result[16·idx +: 16], then carry ← c_out and idx ← idx+1.
- Last limb (idx = WORDS−1): additionally write result[W] = a[W−1] ^ b_l[15] ^ c_out. This is the sign extension of the (W+1)-bit exact sum. Then go to DONE.
- DONE: out_sum = result register, held stable while out_valid && !out_ready. On out_ready go to IDLE.
- Input changes: in_a, in_b and in_sub are ignored outside the accept edge. Changing them during RUN has no effect.
- No accept while in RUN or DONE; in_ready=0 there.
- Arithmetic: out_sum equals sext(a) ± sext(b) computed at W+1 bits, for all inputs including a = b = −2^(W−1).

## Timing
- Reset (rst_n=0 at an edge) forces, from the next cycle:
  - state=IDLE, in_ready=1, out_valid=0;
  - out_sum=0, idx=0, carry=0.
- Reset mid-RUN or mid-DONE abandons the operation. No result is emitted.
- Latency:
  - Accept at edge k → limbs processed at edges k+1..k+WORDS.
  - out_valid high after edge k+WORDS.
  - Result consumed at the first edge ≥ k+WORDS+1 with out_ready=1.
- Throughput: one request per WORDS+2 cycles with out_ready tied high. The next accept is possible at edge k+WORDS+2.
- in_ready and out_valid are pure state decodes (registered). There is no combinational path from any input to any output.
- out_sum changes only during RUN, and is 0 or stale before the first DONE.

## Structure
- Shared package seq_s_mpadd_pkg:
  - LIMB_W=16;
  - state enum {IDLE, RUN, DONE};
  - op encoding (OP_ADD=0, OP_SUB=1).
- Sub-module s_rca16_cin: the 16-bit ripple-carry slice with carry-in.
  - Built from the generated half/full-adder cells, with fa0 replacing the half adder.
  - Outputs s[15:0] and c_out, purely combinational.
  - Instantiated once.
- Top module contains the FSM, idx counter (clog2(WORDS) bits), carry flop, operand registers, and the result register.

## Test plan
WORDS=4 throughout; values in hex.
- Cross-limb carry: add 0000_0000_0000_FFFF + 0000_0000_0000_0001 → out_sum = 0_0000_0000_0001_0000. out_valid rises exactly 4 cycles after accept.
- Positive overflow: add 7FFF_FFFF_FFFF_FFFF + 1 → 0_8000_0000_0000_0000. Also add FFFF_FFFF_FFFF_FFFF (−1) + 1 → 0.
- Negative limit: add 8000_0000_0000_0000 + 8000_0000_0000_0000 → 1_0000_0000_0000_0000.
- Subtract: 0 − 8000_0000_0000_0000 → 0_8000_0000_0000_0000. Also 5 − 7 → 1_FFFF_FFFF_FFFF_FFFE.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - out_sum and out_valid stay stable; in_ready stays 0.
  - in_valid pulses are not accepted.
  - Toggling in_a/in_b during RUN does not change the result.
- Reset and throughput:
  - Assert rst_n=0 during RUN, limb 2 → next cycle in_ready=1, out_valid=0, out_sum=0.
  - A subsequent request completes correctly.
  - Back-to-back requests with out_ready=1 are accepted every 6 cycles.

Source files
------------

// File: rtl/seq_s_mpadd_pkg.sv
// Shared definitions for the multi-precision signed adder sequencer:
// limb width, FSM state encoding, operation encoding and the full-adder cell.
package seq_s_mpadd_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // One full-adder cell: returns {carry_out, sum}
    function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/s_rca16_cin.sv
// 16-bit ripple-carry adder slice with carry-in, one full-adder cell per bit.
// Purely combinational; shared across limbs by the sequencer.
module s_rca16_cin
    import seq_s_mpadd_pkg::*;
(
    input  logic [LIMB_W-1:0] a_i,
    input  logic [LIMB_W-1:0] b_i,
    input  logic              c_i,
    output logic [LIMB_W-1:0] s_o,
    output logic              c_o
);

    logic [LIMB_W:0] c_s;

    assign c_s[0] = c_i;

    for (genvar i = 0; i < LIMB_W; i++) begin : g_fa
        assign {c_s[i+1], s_o[i]} = fa(a_i[i], b_i[i], c_s[i]);
    end

    assign c_o = c_s[LIMB_W];

endmodule

// File: rtl/seq_s_mpadd16.sv
// Multi-precision signed add/subtract sequencer: one 16-bit limb per clock
// through a single shared slice, producing an exact (W+1)-bit signed result.
module seq_s_mpadd16
    import seq_s_mpadd_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int W     = LIMB_W * WORDS,
    localparam int IW    = $clog2(WORDS)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sub,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   out_sum
);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          sub_q, sub_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W:0]    res_q, res_d;

    logic [LIMB_W-1:0] a_l_s, b_l_s, s_s;
    logic              c_out_s;
    logic              last_s;

    assign a_l_s  = a_q[LIMB_W*idx_q +: LIMB_W];
    assign b_l_s  = b_q[LIMB_W*idx_q +: LIMB_W] ^ {LIMB_W{sub_q == OP_SUB}};
    assign last_s = (idx_q == IW'(WORDS - 1));

    s_rca16_cin u_slice (
        .a_i (a_l_s),
        .b_i (b_l_s),
        .c_i (carry_q),
        .s_o (s_s),
        .c_o (c_out_s)
    );

    // Next-state logic: accept, limb stepping and result hand-off
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sub_d   = in_sub;
                    carry_d = in_sub;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d[LIMB_W*idx_q +: LIMB_W] = s_s;
                carry_d = c_out_s;
                idx_d   = idx_q + IW'(1);
                // top limb: a[W-1] ^ b_l[15] ^ c_out is the sign of the exact W+1 sum
                if (last_s) begin
                    res_d[W] = a_l_s[LIMB_W-1] ^ b_l_s[LIMB_W-1] ^ c_out_s;
                    state_d  = DONE;
                end else begin
                    state_d  = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = res_q;

endmodule

// File: tb/tb_seq_s_mpadd16.sv
// Self-checking bench for seq_s_mpadd16 (WORDS=4): arithmetic reference model,
// per-cycle compare process, and hand-computed directed expectations.
module tb_seq_s_mpadd16;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_sub;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_sum;

    int n_vec = 0;
    int n_err = 0;

    seq_s_mpadd16 #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sub    (in_sub),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    always #5 clk = ~clk;

    // Exact signed sum/difference at W+1 bits
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
        logic signed [W:0] x;
        logic signed [W:0] y;
        x = $signed({a[W-1], a});
        y = $signed({b[W-1], b});
        return sub ? (x - y) : (x + y);
    endfunction

    task automatic chk(input string nm, input logic [W:0] got, input logic [W:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    // Behavioural model: 0 = idle, 1 = computing, 2 = result held
    int         m_phase = 0;
    int         m_cnt   = 0;
    logic [W:0] m_pend  = '0;
    logic [W:0] m_sum   = '0;
    bit         m_known = 1'b0;
    bit         chk_en  = 1'b0;
    int         cyc     = 0;
    int         acc_cyc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            m_phase <= 0;
            m_sum   <= '0;
            m_known <= 1'b1;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pend  <= ref_sum(in_a, in_b, in_sub);
                    m_cnt   <= WORDS;
                    m_phase <= 1;
                    m_known <= 1'b0;
                    acc_cyc.push_back(cyc);
                end
                1: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) begin
                        m_phase <= 2;
                        m_sum   <= m_pend;
                        m_known <= 1'b1;
                    end
                end
                2: if (out_ready) m_phase <= 0;
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, (m_phase == 0)});
            chk("out_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, (m_phase == 2)});
            if (m_known) chk("out_sum", out_sum, m_sum);
        end
    end

    task automatic scramble();
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
        in_sub = 1'($urandom_range(0, 1));
    endtask

    // Issue one request from idle, check latency and literal result, then consume
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      input logic [W:0] want, input int hold);
        int t;
        int lat;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 65'(t), 65'd0);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_sub = sub;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            scramble();
            @(negedge clk);
            lat++;
        end
        chk("latency", 65'(lat), 65'(WORDS));
        chk("lit_sum", out_sum, want);
        for (int i = 0; i < hold; i++) begin
            scramble();
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("held_sum", out_sum, want);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic [W-1:0] edge_v [0:5];
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sub = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", {{W{1'b0}}, in_ready}, 65'd1);
        chk("rst_out_valid", {{W{1'b0}}, out_valid}, 65'd0);
        chk("rst_out_sum", out_sum, 65'd0);
        chk_en = 1'b1;

        op(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 65'h0_0000_0000_0001_0000, 0);
        op(64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 65'h0_8000_0000_0000_0000, 1);
        op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 65'h0_0000_0000_0000_0000, 0);
        op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 65'h1_0000_0000_0000_0000, 2);
        op(64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 65'h0_8000_0000_0000_0000, 0);
        op(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFE, 10);

        // reset while limb 2 is about to be processed
        in_valid = 1'b1;
        in_a = 64'h1234_5678_9ABC_DEF0;
        in_b = 64'h0FED_CBA9_8765_4321;
        in_sub = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_in_ready", {{W{1'b0}}, in_ready}, 65'd1);
        chk("midrun_out_valid", {{W{1'b0}}, out_valid}, 65'd0);
        chk("midrun_out_sum", out_sum, 65'd0);
        rst_n = 1'b1;
        op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 65'h0_2222_2222_2222_2211, 0);

        edge_v[0] = 64'h0;
        edge_v[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        edge_v[2] = 64'h8000_0000_0000_0000;
        edge_v[3] = 64'h7FFF_FFFF_FFFF_FFFF;
        edge_v[4] = 64'h0000_0000_FFFF_FFFF;
        edge_v[5] = 64'h0001_0000_0000_0000;
        for (int n = 0; n < 25; n++) begin
            ra = (n % 3 == 0) ? edge_v[$urandom_range(0, 5)] : {$urandom, $urandom};
            rb = (n % 4 == 0) ? edge_v[$urandom_range(0, 5)] : {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            op(ra, rb, rs, ref_sum(ra, rb, rs), $urandom_range(0, 3));
        end

        // back-to-back with out_ready tied high
        acc_cyc.delete();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            scramble();
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        out_ready = 1'b0;
        chk("tput_count_ok", 65'(acc_cyc.size() >= 6), 65'd1);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            chk("tput_gap", 65'(acc_cyc[i] - acc_cyc[i-1]), 65'(WORDS + 2));
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
